// File: rtl/cache_fill_fsm_if.sv
// Cache fill bus: pipeline miss request, main-memory read/return and
// data/tag array write ports of the cache fill controller.
// master = fill controller side, slave = pipeline/memory/array side.
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_read, memory_address, write_data_array,
           fill_addr, fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_read, memory_address, write_data_array,
           fill_addr, fill_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, issues 8 back-to-back word reads
// for the 16-byte block and writes each returned word into the data array,
// strobing the tag array with the last word.
// Build option: FILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missing
// word and wraps within the block; otherwise words are fetched 0..7.
module cache_fill_fsm (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state, state_nxt;
  logic [11:0] blk;        // block number, address bits [15:4]
  logic [2:0]  start_idx;  // word index of the first fetched word
  logic [3:0]  issue_cnt;  // bit 3 = all 8 reads issued
  logic [3:0]  recv_cnt;
  logic [2:0]  issue_idx;
  logic [2:0]  recv_idx;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.miss_address[3:0];

  // Word indices wrap inside the block, so addresses never leave it.
  // Once all reads are out, the issue index sticks at the last word.
  always_comb begin
    issue_idx = start_idx + (issue_cnt[3] ? 3'd7 : issue_cnt[2:0]);
    recv_idx  = start_idx + recv_cnt[2:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Block latch and independent issue/receive counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk       <= '0;
      start_idx <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else if (state == IDLE) begin
      if (bus.miss_detected) begin
        blk <= bus.miss_address[15:4];
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        start_idx <= bus.miss_address[3:1];
`else
        start_idx <= '0;
`endif
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
    end else begin
      if (!issue_cnt[3])          issue_cnt <= issue_cnt + 4'd1;
      if (bus.memory_data_valid)  recv_cnt  <= recv_cnt + 4'd1;
    end
  end

  // Next state and all outputs; everything is zero outside FILL.
  always_comb begin
    state_nxt            = state;
    bus.fsm_busy         = 1'b0;
    bus.memory_read      = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.fill_addr        = '0;
    bus.fill_data        = '0;
    bus.write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) state_nxt = FILL;
      end
      FILL: begin
        bus.fsm_busy       = 1'b1;
        bus.memory_read    = !issue_cnt[3];
        bus.memory_address = {blk, issue_idx, 1'b0};
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.fill_addr        = {blk, recv_idx, 1'b0};
          bus.fill_data        = bus.memory_data;
          if (recv_cnt == 4'd7) begin
            bus.write_tag_array = 1'b1;
            state_nxt           = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port miss_detected, input, 1: cache miss request from the pipeline memory stage.
REQ-004 SHALL have port miss_address, input, 16: byte address of the missing word.
REQ-005 SHALL have port memory_data_valid, input, 1: main memory returns one word this cycle.
REQ-006 SHALL have port memory_data, input, 16: returned word, meaningful when memory_data_valid=1.
REQ-007 SHALL have port fsm_busy, output, 1: fill in progress; pipeline stalls while high.
REQ-008 SHALL have port memory_read, output, 1: read request to main memory.
REQ-009 SHALL have port memory_address, output, 16: byte address of the current memory read.
REQ-010 SHALL have port write_data_array, output, 1: data-array write strobe.
REQ-011 SHALL have port fill_addr, output, 16: byte address of the word written to the data array.
REQ-012 SHALL have port fill_data, output, 16: word written to the data array; equals memory_data.
REQ-013 SHALL have port write_tag_array, output, 1: tag/valid write strobe for the filled block.

Function
REQ-014 SHALL treat a block as 8 words of 16 bits (16 bytes); base = miss_address & 16'hFFF0.
REQ-015 SHALL implement two states: IDLE and FILL.
REQ-016 In IDLE, if miss_detected=1 at a rising edge, SHALL latch base and the start word index, clear the issue count and receive count (both 3-bit plus done flag), and enter FILL.
REQ-017 In IDLE, SHALL drive fsm_busy=0, memory_read=0, write_data_array=0, write_tag_array=0, and SHALL ignore memory_data_valid.
REQ-018 In FILL, SHALL drive fsm_busy=1 and ignore miss_detected.
REQ-019 In FILL, while issue count < 8, SHALL drive memory_read=1 and memory_address = base + 2*word_idx(issue count), then increment issue count each cycle; 8 consecutive requests, no gaps.
REQ-020 After 8 issues, SHALL drive memory_read=0 and hold memory_address at its last value.
REQ-021 In FILL, on each cycle with memory_data_valid=1, SHALL assert write_data_array combinationally that cycle, drive fill_addr = base + 2*word_idx(receive count) and fill_data = memory_data, then increment receive count.
REQ-022 SHALL accept data in the same cycle as an outstanding issue; issue and receive advance independently.
REQ-023 On the cycle the 8th valid word arrives, SHALL assert write_tag_array=1 together with write_data_array=1 and return to IDLE at the next edge; fsm_busy drops the following cycle.
REQ-024 Address arithmetic SHALL be 16-bit modulo; word index wraps modulo 8 inside the block, never crossing the block boundary.
REQ-025 A miss_detected asserted in the same cycle the FSM returns to IDLE SHALL be accepted at the next edge, not dropped, as long as it is still asserted then.
REQ-026 With memory latency L cycles (data for request k valid L cycles after issue k), fsm_busy SHALL stay high for exactly 8+L cycles.

Reset
REQ-027 On rst=1, SHALL enter IDLE immediately, clear all counters and latched base, and drive every output to 0.
REQ-028 Reset during FILL SHALL abort the fill with no write_tag_array pulse; words returned after reset release SHALL be ignored.

Configuration
REQ-029 Macro FILL_CRITICAL_WORD_FIRST_EN defined: word_idx(n) = (miss_address[3:1] + n) mod 8 for both issue and receive, so the missing word is fetched first.
REQ-030 Macro FILL_CRITICAL_WORD_FIRST_EN undefined: word_idx(n) = n, so words are fetched 0..7 in order; port list identical in both builds.

Verification
REQ-031 Miss at 0x1234, latency 4, macro undefined -> memory_address 0x1230,0x1232,...,0x123E on 8 consecutive cycles; write_data_array on 8 cycles with fill_addr 0x1230..0x123E; write_tag_array once with the 8th word; fsm_busy high 12 cycles.
REQ-032 Same miss, macro defined -> issue and fill order 0x1234,0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232.
REQ-033 Miss at 0xFFFE, macro defined -> first address 0xFFFE, second 0xFFF0; no address outside 0xFFF0..0xFFFE.
REQ-034 memory_data_valid pulsed in IDLE, and miss_detected pulsed mid-FILL -> no write strobes, no restart, fill completes unchanged.
REQ-035 rst asserted after 5th word received -> all outputs 0 immediately, no write_tag_array; a new miss after release fills the block from its first word.
REQ-036 miss_detected held high through fill completion -> second fill starts the cycle after fsm_busy falls; back-to-back fills are both complete.
